// File: rtl/order_content_arbiter.sv
// Single-port access controller for the order-content RAM: round-robin between one writer and one reader.
// Latency: a read accepted at edge k returns rd_resp_valid/rd_resp_data in the cycle after edge k+1; writes land at edge k+1.
// Backpressure: wr_ready/rd_ready grant at most one requester per cycle; read responses cannot be stalled.
//
// Ports:
//   axis_aclk / axis_resetn      clock, asynchronous active-low reset
//   wr_valid/wr_ready/addr/data  write requester (valid-ready)
//   rd_valid/rd_ready/rd_addr    read requester (valid-ready)
//   rd_resp_valid/rd_resp_data   read response pulse and record (data straight from ram_dout)
//   init_done                    high once requests can be accepted
//   ram_addr/ram_din/ram_we      registered RAM port drive
//   ram_dout                     RAM read data
//
// Build option: define ORDER_CONTENT_INIT_CLEAR_EN to zero the whole RAM after reset
// before any request is accepted. Without it the block starts in RUN and init_done is tied high.
module order_content_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 976
) (
  input  logic                  axis_aclk,
  input  logic                  axis_resetn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_resp_valid,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef ORDER_CONTENT_INIT_CLEAR_EN
  localparam logic [0:0] ST_RESET = ST_INIT;
`else
  localparam logic [0:0] ST_RESET = ST_RUN;
`endif

  logic [0:0]            state_q, state_d;
  logic                  prio_rd_q, prio_rd_d;   // 0 favours write, 1 favours read
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic [1:0]            rd_pipe_q, rd_pipe_d;   // [0]: addr registered, [1]: RAM data out
  logic                  run;
  logic                  wr_gnt;
  logic                  rd_gnt;

`ifdef ORDER_CONTENT_INIT_CLEAR_EN
  // One extra bit so the sweep ends on the MSB instead of wrapping back to 0.
  logic [ADDR_WIDTH:0]   sweep_q, sweep_d;
`endif

  // Gating with the reset keeps ready low while the block is held in reset.
  assign run      = axis_resetn && (state_q == ST_RUN);
  assign wr_ready = run && wr_valid && (!rd_valid || !prio_rd_q);
  assign rd_ready = run && rd_valid && (!wr_valid || prio_rd_q);
  assign wr_gnt   = wr_ready;
  assign rd_gnt   = rd_ready;

  always_comb begin
    state_d    = state_q;
    prio_rd_d  = prio_rd_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rd_pipe_d  = {rd_pipe_q[0], rd_gnt};
`ifdef ORDER_CONTENT_INIT_CLEAR_EN
    sweep_d    = sweep_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef ORDER_CONTENT_INIT_CLEAR_EN
        ram_we_d   = 1'b1;
        ram_addr_d = sweep_q[ADDR_WIDTH-1:0];
        ram_din_d  = '0;
        sweep_d    = sweep_q + 1'b1;
        if (sweep_d[ADDR_WIDTH]) begin
          state_d = ST_RUN;
        end
`else
        state_d = ST_RUN;
`endif
      end
      default: begin
        if (wr_gnt) begin
          ram_we_d   = 1'b1;
          ram_addr_d = wr_addr;
          ram_din_d  = wr_data;
        end else if (rd_gnt) begin
          ram_addr_d = rd_addr;
        end
        // Only a contended grant hands priority to the other side.
        if (wr_valid && rd_valid && (wr_gnt || rd_gnt)) begin
          prio_rd_d = !prio_rd_q;
        end
      end
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q    <= ST_RESET;
      prio_rd_q  <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      rd_pipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      prio_rd_q  <= prio_rd_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      rd_pipe_q  <= rd_pipe_d;
    end
  end

`ifdef ORDER_CONTENT_INIT_CLEAR_EN
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      sweep_q <= '0;
    end else begin
      sweep_q <= sweep_d;
    end
  end

  assign init_done = (state_q == ST_RUN);
`else
  assign init_done = 1'b1;
`endif

  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_din       = ram_din_q;
  assign rd_resp_valid = rd_pipe_q[1];
  assign rd_resp_data  = ram_dout;

endmodule

// File: tb/tb_order_content_arbiter.sv
// Testbench for order_content_arbiter: write-first single-port RAM model, reference contents array,
// expected-response queue and an arbitration model derived from the round-robin rules.
module tb_order_content_arbiter;

  localparam int AW = 12;
  localparam int DW = 976;
  localparam int DEPTH = 1 << AW;

  logic          axis_aclk;
  logic          axis_resetn;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_resp_valid;
  logic [DW-1:0] rd_resp_data;
  logic          init_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  order_content_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .axis_aclk     (axis_aclk),
    .axis_resetn   (axis_resetn),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_data  (rd_resp_data),
    .init_done     (init_done),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .ram_we        (ram_we),
    .ram_dout      (ram_dout)
  );

  initial begin
    axis_aclk = 1'b0;
    forever #5 axis_aclk = ~axis_aclk;
  end

  // Write-first single-port RAM, zero at power-up.
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end
  always @(posedge axis_aclk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout      <= mem[ram_addr];
    end
  end

  // Reference model state.
  typedef struct {
    int            due;
    logic [DW-1:0] dat;
  } rsp_t;

  logic [DW-1:0] ref_mem [DEPTH];
  rsp_t          rq[$];
  logic          mdl_prio_rd;
  logic          mdl_run;
  int            cyc;
  int            resp_seen;
  logic          w_acc;
  logic          r_acc;
  int            n_chk;
  int            n_err;
  logic [AW-1:0] pool [16];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (low 64 bits) t=%0t", tag, got[63:0], exp[63:0], $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 31; i++) r = {r[DW-33:0], 32'($urandom())};
    return r;
  endfunction

  // One clock cycle: check readies and responses at the falling edge, update the model,
  // then advance to just after the next rising edge where stimulus may change.
  task automatic cycle();
    logic ew, er, ev;
    @(negedge axis_aclk);
    ew = mdl_run && wr_valid && (!rd_valid || !mdl_prio_rd);
    er = mdl_run && rd_valid && (!wr_valid || mdl_prio_rd);
    chk("wr_ready", wr_ready, ew);
    chk("rd_ready", rd_ready, er);
    w_acc = wr_valid && wr_ready;
    r_acc = rd_valid && rd_ready;
    ev = (rq.size() > 0) && (rq[0].due == cyc);
    chk("rsp_vld", rd_resp_valid, ev);
    if (ev) begin
      if (rd_resp_valid) chk("rsp_dat", rd_resp_data, rq[0].dat);
      void'(rq.pop_front());
    end
    if (rd_resp_valid) resp_seen++;
    if (mdl_run && wr_valid && rd_valid) mdl_prio_rd = !mdl_prio_rd;
    if (r_acc) rq.push_back('{due: cyc + 2, dat: ref_mem[rd_addr]});
    if (w_acc) ref_mem[wr_addr] = wr_data;
    @(posedge axis_aclk);
    cyc++;
    #1;
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    chk("wr_acc", w_acc, 1'b1);
    wr_valid = 1'b0;
  endtask

  task automatic do_rd(input logic [AW-1:0] a);
    rd_valid = 1'b1; rd_addr = a;
    cycle();
    chk("rd_acc", r_acc, 1'b1);
    rd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] pat;
    n_chk = 0; n_err = 0; cyc = 0; resp_seen = 0;
    w_acc = 1'b0; r_acc = 1'b0;
    mdl_prio_rd = 1'b0; mdl_run = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    pool[0] = '0; pool[1] = 12'hFFF; pool[2] = 12'h005; pool[3] = 12'h001;
    for (int i = 4; i < 16; i++) pool[i] = AW'($urandom_range(0, DEPTH - 1));

    // Reset with both requesters asserting: nothing may be granted.
    axis_resetn = 1'b0;
    wr_valid = 1'b1; rd_valid = 1'b1;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) @(posedge axis_aclk);
    #1;
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_rsp_vld", rd_resp_valid, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, '0);
    chk("rst_ram_din", ram_din, '0);
`ifdef ORDER_CONTENT_INIT_CLEAR_EN
    chk("rst_init_done", init_done, 1'b0);
    axis_resetn = 1'b1;
    #1;
    chk("sweep_rdy0", wr_ready | rd_ready, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge axis_aclk);
      #1;
      chk("sweep_we", ram_we, 1'b1);
      chk("sweep_addr", ram_addr, i);
      chk("sweep_din", ram_din, '0);
      chk("sweep_done", init_done, (i == DEPTH - 1));
      chk("sweep_wr_rdy", wr_ready, (i == DEPTH - 1));
      chk("sweep_rd_rdy", rd_ready, 1'b0);
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    mdl_run = 1'b1;
    idle(1);
    do_rd(12'hABC);
    idle(3);
`else
    chk("rst_init_done", init_done, 1'b1);
    wr_valid = 1'b0; rd_valid = 1'b0;
    axis_resetn = 1'b1;
    mdl_run = 1'b1;
    idle(1);
`endif

    // Contention: six cycles of both requesting, grants alternate starting with write.
    wr_valid = 1'b1; rd_valid = 1'b1;
    wr_addr = 12'h100; wr_data = rnd_data(); rd_addr = 12'h001;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("cont_w", w_acc, (i % 2 == 0));
      chk("cont_r", r_acc, (i % 2 == 1));
      if (w_acc) begin wr_addr = wr_addr + 1'b1; wr_data = rnd_data(); end
      if (r_acc) rd_addr = rd_addr + 1'b1;
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    idle(3);

    // Single write then read.
    pat = rnd_data();
    do_wr(12'h005, pat);
    idle(1);
    do_rd(12'h005);
    idle(3);

    // Read on the cycle right after a write to the same address.
    pat = rnd_data();
    do_wr(12'hFFF, pat);
    do_rd(12'hFFF);
    idle(3);

    // Streaming reads of 0..7 with distinct contents.
    for (int i = 0; i < 8; i++) do_wr(AW'(i), rnd_data());
    idle(3);
    resp_seen = 0;
    for (int i = 0; i < 8; i++) do_rd(AW'(i));
    idle(3);
    chk("stream_cnt", resp_seen, 8);

    // Random traffic over a small address pool so reads hit recent writes.
    for (int n = 0; n < 2000; n++) begin
      if (!wr_valid && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b1;
        wr_addr  = pool[$urandom_range(0, 15)];
        wr_data  = rnd_data();
      end
      if (!rd_valid && $urandom_range(0, 1) == 0) begin
        rd_valid = 1'b1;
        rd_addr  = pool[$urandom_range(0, 15)];
      end
      cycle();
      if (w_acc) wr_valid = 1'b0;
      if (r_acc) rd_valid = 1'b0;
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    idle(4);

    // Reset while a read response is in flight.
    do_rd(12'h005);
    rd_valid = 1'b1;
    axis_resetn = 1'b0;
    #1;
    chk("mid_rsp_vld", rd_resp_valid, 1'b0);
    chk("mid_ram_we", ram_we, 1'b0);
    chk("mid_ram_addr", ram_addr, '0);
    chk("mid_ram_din", ram_din, '0);
    chk("mid_rd_ready", rd_ready, 1'b0);
`ifdef ORDER_CONTENT_INIT_CLEAR_EN
    chk("mid_init_done", init_done, 1'b0);
`else
    chk("mid_init_done", init_done, 1'b1);
`endif
    rq.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge axis_aclk);
      chk("mid_rsp_hold", rd_resp_valid, 1'b0);
    end
    @(posedge axis_aclk);
    #1;
    rd_valid = 1'b0;
    axis_resetn = 1'b1;
    mdl_prio_rd = 1'b0;
`ifdef ORDER_CONTENT_INIT_CLEAR_EN
    for (int i = 0; i < 4; i++) begin
      @(posedge axis_aclk);
      #1;
      chk("resweep_we", ram_we, 1'b1);
      chk("resweep_addr", ram_addr, i);
      chk("resweep_rsp", rd_resp_valid, 1'b0);
    end
`else
    idle(3);
    // Priority must be back on the write side after reset.
    wr_valid = 1'b1; rd_valid = 1'b1;
    wr_addr = 12'h200; wr_data = rnd_data(); rd_addr = 12'h005;
    cycle();
    chk("post_rst_prio", w_acc, 1'b1);
    wr_valid = 1'b0;
    cycle();
    chk("post_rst_rd", r_acc, 1'b1);
    rd_valid = 1'b0;
    idle(3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/order_content_arbiter.md
# order_content_arbiter

Single-port access controller for the 4096x976 order-content RAM in the router output-port lookup path. Shares the RAM's one read/write port between a write requester (order insert/update) and a read requester (order lookup), using round-robin arbitration under contention. Registers all RAM-side signals and returns read data with fixed latency. Optionally clears the whole RAM after reset before accepting traffic.

## Interface
- ADDR_WIDTH, 12, RAM address width; depth = 2^ADDR_WIDTH
- DATA_WIDTH, 976, order record width
- axis_aclk  in  1  sole clock; RAM is clocked by the same clock
- axis_resetn  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write record
- rd_valid  in  1  read request
- rd_ready  out  1  read accepted this cycle when rd_valid && rd_ready
- rd_addr  in  ADDR_WIDTH  read address
- rd_resp_valid  out  1  one-cycle pulse, read data valid
- rd_resp_data  out  DATA_WIDTH  read record (passed through from ram_dout)
- init_done  out  1  high once the block accepts requests
- ram_addr  out  ADDR_WIDTH  to RAM addr_a
- ram_din  out  DATA_WIDTH  to RAM din_a
- ram_we  out  1  to RAM we_a
- ram_dout  in  DATA_WIDTH  from RAM dout_a

## Operation
- States: INIT (clear sweep), RUN. Reset enters INIT if clearing is compiled in, otherwise RUN.
- INIT: the block issues ram_we=1 and ram_din=0 to addresses 0..2^ADDR_WIDTH-1, one per cycle. wr_ready=rd_ready=0. After the last address it moves to RUN and sets init_done=1.
- RUN arbitration:
  - Only one requester valid: it gets ready=1.
  - Both valid: only the side selected by the priority bit gets ready=1. The priority bit toggles after every contended grant.
  - Uncontended grants leave the priority bit unchanged.
  - Priority bit resets to favour write.
- ready is combinational from valid and the priority bit. At most one grant per cycle. A requester holds valid, addr and data stable until accepted.
- Write grant: register ram_we=1, ram_addr=wr_addr, ram_din=wr_data.
- Read grant: register ram_we=0, ram_addr=rd_addr. A 2-stage valid pipe produces rd_resp_valid.
- No grant: ram_we registers 0. ram_addr and ram_din hold their last values.
- rd_resp_data = ram_dout, unregistered inside this block.
- No response backpressure: the consumer must take rd_resp_valid when it pulses.
- The RAM is write-first. A read of the address written on the previous grant returns the new data.

## Timing
- Reset values: wr_ready=0, rd_ready=0, rd_resp_valid=0, init_done=0 (1 if clearing is compiled out), ram_we=0, ram_addr=0, ram_din=0, priority=write, sweep counter=0.
- Read latency: request accepted at edge k; RAM samples at edge k+1; rd_resp_valid is high for exactly the cycle after edge k+1, with data valid. Back-to-back reads give one response per cycle.
- Write: RAM is updated at edge k+1 after acceptance at edge k.
- INIT lasts exactly 2^ADDR_WIDTH cycles (4096 by default). rd_ready and wr_ready become possible in the first cycle after the last clear write is registered.
- Sweep counter is ADDR_WIDTH+1 bits; the sweep terminates when the MSB sets, with no wrap-around.
- Reset asserted mid-operation: all state clears immediately. In-flight read responses are dropped (rd_resp_valid=0). Under clearing the sweep restarts at address 0.

## Configuration
- ORDER_CONTENT_INIT_CLEAR_EN defined: INIT state and sweep counter are present; init_done rises after the 4096-cycle zero sweep.
- ORDER_CONTENT_INIT_CLEAR_EN undefined: no INIT state; RUN is entered from reset, init_done is tied 1, and RAM contents are undefined until written.

## Test plan
- Clear sweep (macro on): release reset, then hold wr_valid=rd_valid=1 -> ready stays 0 for 4096 cycles, ram_we=1 with addresses 0..4095 in order, then init_done=1. A read of 0xABC returns all-zero.
- Single write then read: write 0x005 with pattern P, then read 0x005 -> rd_resp_valid pulses 2 edges after the read acceptance with data=P.
- Contention: wr_valid and rd_valid both held high for 6 cycles -> grants alternate W,R,W,R,W,R starting with write, exactly one ready per cycle.
- Read-after-write: write 0xFFF=Q, read 0xFFF on the very next cycle -> response data=Q (write-first).
- Streaming reads: 8 back-to-back reads of addresses 0..7 with distinct contents -> 8 consecutive rd_resp_valid cycles, returned in order.
- Reset mid-read: accept a read, assert axis_resetn=0 before the response -> rd_resp_valid stays 0. All outputs reach reset values asynchronously and the sweep restarts at 0 (macro on).
